// File: rtl/blink_ctrl.sv
// blink_ctrl: plays a PAT_W-step LED pattern, one step every max(div,1) cycles.
// Latency: led_out/tick registered, first step on the start edge; cfg via valid/ready
// with a 1-deep shadow, cfg_ready low while it is full. Define BLINK_CTRL_ONESHOT_EN for one-shot playback.
module blink_ctrl #(
  parameter int CNT_W   = 32,
  parameter int PAT_W   = 8,
  parameter int RST_DIV = 2
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [PAT_W-1:0] cfg_pat,
  output logic             led_out,
  output logic             tick,
  output logic             busy
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam int                IDX_W    = $clog2(PAT_W);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   div_q, div_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [CNT_W-1:0]   pend_div_q, pend_div_d;
  logic [PAT_W-1:0]   pend_pat_q, pend_pat_d;
  logic               pend_vld_q, pend_vld_d;
  logic               led_q, led_d;
  logic               tick_q, tick_d;
  logic               cfg_acc;

  // A divider of 0 behaves as 1 so the step period is never empty.
  function automatic logic [CNT_W-1:0] eff_div(input logic [CNT_W-1:0] d);
    return (d == '0) ? CNT_ONE : d;
  endfunction

  assign cfg_ready = ~pend_vld_q;
  assign cfg_acc   = cfg_valid & ~pend_vld_q;
  assign led_out   = led_q;
  assign tick      = tick_q;
  assign busy      = (state_q == RUN);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    div_d      = div_q;
    pat_d      = pat_q;
    pend_div_d = pend_div_q;
    pend_pat_d = pend_pat_q;
    pend_vld_d = pend_vld_q;
    led_d      = led_q;
    tick_d     = 1'b0;

    case (state_q)
      IDLE: begin
        // A shadow left over from a stopped run drains here before new offers.
        if (pend_vld_q) begin
          div_d      = pend_div_q;
          pat_d      = pend_pat_q;
          pend_vld_d = 1'b0;
        end else if (cfg_acc) begin
          div_d = cfg_div;
          pat_d = cfg_pat;
        end
        if (start && !stop) begin
          state_d = RUN;
          cnt_d   = eff_div(div_d) - CNT_ONE;
          idx_d   = '0;
          led_d   = pat_d[0];
        end
      end

      RUN: begin
        if (cfg_acc) begin
          pend_div_d = cfg_div;
          pend_pat_d = cfg_pat;
          pend_vld_d = 1'b1;
        end
        if (stop) begin
          state_d = IDLE;
          led_d   = 1'b0;
          cnt_d   = '0;
          idx_d   = '0;
        end else if (cnt_q == '0) begin
          tick_d = 1'b1;
          if (pend_vld_q) begin
            div_d      = pend_div_q;
            pat_d      = pend_pat_q;
            pend_vld_d = 1'b0;
            idx_d      = '0;
          end else begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
          end
          cnt_d = eff_div(div_d) - CNT_ONE;
          led_d = pat_d[idx_d];
`ifdef BLINK_CTRL_ONESHOT_EN
          if (!pend_vld_q && (idx_q == IDX_LAST)) begin
            state_d = IDLE;
            led_d   = 1'b0;
            cnt_d   = '0;
            idx_d   = '0;
          end
`endif
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      div_q      <= CNT_W'(RST_DIV);
      pat_q      <= '1;
      pend_div_q <= '0;
      pend_pat_q <= '0;
      pend_vld_q <= 1'b0;
      led_q      <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      div_q      <= div_d;
      pat_q      <= pat_d;
      pend_div_q <= pend_div_d;
      pend_pat_q <= pend_pat_d;
      pend_vld_q <= pend_vld_d;
      led_q      <= led_d;
      tick_q     <= tick_d;
    end
  end

endmodule

// File: doc/blink_ctrl.md
BLINK_CTRL -- requirements
Module: blink_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: width of the divider counter and of cfg_div.
REQ-002 The block SHALL have parameter PAT_W, default 8: pattern length in steps; minimum 2.
REQ-003 The block SHALL have parameter RST_DIV, default 2: divider value loaded at reset.
REQ-004 The block SHALL have port clk_in, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous assert and active-low.
REQ-006 The block SHALL have port start, input, 1 bit: begin pattern playback, sampled every cycle.
REQ-007 The block SHALL have port stop, input, 1 bit: halt playback, sampled every cycle.
REQ-008 The block SHALL have port cfg_valid, input, 1 bit: a new configuration is offered.
REQ-009 The block SHALL have port cfg_ready, output, 1 bit: the block can accept a configuration.
REQ-010 The block SHALL have port cfg_div, input, CNT_W bits: clk_in cycles per pattern step.
REQ-011 The block SHALL have port cfg_pat, input, PAT_W bits: LED pattern; bit 0 is played first.
REQ-012 The block SHALL have port led_out, output, 1 bit: registered current pattern bit.
REQ-013 The block SHALL have port tick, output, 1 bit: one-cycle pulse at each step boundary.
REQ-014 The block SHALL have port busy, output, 1 bit: high while in state RUN.

Function
REQ-015 The block SHALL implement states IDLE and RUN, with a 1-deep shadow register (pend_div, pend_pat, pend_vld).
REQ-016 A configuration SHALL transfer on any cycle where cfg_valid and cfg_ready are both 1.
- cfg_ready = ~pend_vld.
REQ-017 In IDLE, an accepted configuration SHALL load the active div/pat registers directly on the next edge; pend_vld stays 0.
REQ-018 In RUN, an accepted configuration SHALL go to the shadow register (pend_vld <= 1).
- The shadow SHALL be applied only on the cycle tick is asserted: active <= pending, pend_vld <= 0, step index <= 0.
REQ-019 A cfg_div value of 0 SHALL be treated as 1.
- The effective period SHALL be max(cfg_div,1) cycles.
REQ-020 The IDLE->RUN transition SHALL occur when start=1 and stop=0.
- Counter <= div-1, index <= 0, led_out <= pat[0] on that same edge.
REQ-021 In RUN, the counter SHALL decrement each cycle; at 0 the block SHALL do all of the following on the next edge:
- assert tick for one cycle;
- reload counter <= div-1;
- advance index, wrapping from PAT_W-1 to 0;
- set led_out <= pat[new index].
REQ-022 With div=1, tick SHALL be high every cycle and the index SHALL advance every cycle.
REQ-023 The RUN->IDLE transition SHALL occur on stop=1, and stop SHALL win over a simultaneous start.
- On that transition: led_out <= 0, tick <= 0, counter and index cleared.
- A pending shadow SHALL be retained and applied directly in IDLE on the next cycle.
REQ-024 start asserted while in RUN SHALL be ignored.
REQ-025 A configuration accepted in the same cycle a tick reload occurs SHALL be stored in the shadow, not applied, and SHALL take effect at the following tick.
REQ-026 Counter arithmetic SHALL be unsigned CNT_W-bit with no overflow path, because the counter only counts down from div-1.

Reset
REQ-027 While rst_n=0, the block SHALL hold:
- state=IDLE, led_out=0, tick=0, busy=0;
- counter=0, index=0;
- div=RST_DIV, pat=all ones;
- pend_vld=0, so cfg_ready=1 after release.
REQ-028 Reset asserted mid-RUN SHALL force the reset values immediately, without waiting for a clock edge.
- Playback resumes only on a new start after rst_n returns to 1.

Configuration
REQ-029 Macro BLINK_CTRL_ONESHOT_EN SHALL control one-shot playback.
- Defined: on the tick that wraps the index from PAT_W-1 to 0, the block returns to IDLE with led_out <= 0, playing the pattern exactly once per start.
- Undefined: playback loops until stop.

Verification
REQ-030 The bench SHALL cover the basic loop.
- Stimulus: reset, configure div=3 and pat=8'b1010_0110 in IDLE, pulse start.
- Required response: led_out = 0,1,1,0,0,1,0,1, each held 3 cycles; tick every 3rd cycle; repeats.
REQ-031 The bench SHALL cover div=0 and div=1.
- Stimulus: run once with div=0 and once with div=1.
- Required response: tick high every cycle in both cases; the index advances each cycle.
REQ-032 The bench SHALL cover a mid-run reconfiguration.
- Stimulus: while running div=4, offer div=2 and pat=8'hFF at counter=2.
- Required response: cfg_ready drops; the new config applies at the next tick; cfg_ready rises; period becomes 2 and led_out=1.
- Also: a second cfg_valid held during pending is not accepted until cfg_ready=1.
REQ-033 The bench SHALL cover simultaneous start and stop.
- Stimulus: assert start=1 and stop=1 in the same cycle from IDLE; separately, assert stop during RUN.
- Required response: the block stays IDLE; stop in RUN gives led_out=0 and busy=0 on the next cycle.
REQ-034 The bench SHALL cover reset mid-run.
- Stimulus: drop rst_n asynchronously between edges while in RUN.
- Required response: led_out=0, busy=0, cfg_ready=1 immediately; after release, the block stays IDLE until start.
REQ-035 The bench SHALL cover one-shot mode, compiled with BLINK_CTRL_ONESHOT_EN.
- Stimulus: div=2, PAT_W=8, pulse start.
- Required response: exactly 8 ticks, then busy=0 and led_out=0.
